// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion controller.
// Cap control is {h,l}; 2'b11 must never reach a DAC.
package sar_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSample,
        StSettle,
        StCompare,
        StDone
    } sar_state_e;

    localparam logic [1:0] CAP_VREFP = 2'b10;
    localparam logic [1:0] CAP_VREFN = 2'b01;
    localparam logic [1:0] CAP_VCM   = 2'b00;

endpackage

// File: rtl/sar_wait_cnt.sv
// Loadable down-counter with a zero flag, shared by the sample, settle and
// comparator-timeout phases of the SAR controller.
module sar_wait_cnt #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sar_logic.sv
// SAR controller: sample, then one settle/strobe/decide round per bit MSB-first,
// driving a monotonic-switching differential cap DAC pair.
module sar_logic
    import sar_pkg::*;
#(
    parameter int unsigned ADC_BITS      = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned COMP_TIMEOUT  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                comp,
    input  logic                comp_done,
    output logic                sample,
    output logic                comp_en,
    output logic [ADC_BITS-1:1] dacp_h,
    output logic [ADC_BITS-1:1] dacp_l,
    output logic [ADC_BITS-1:1] dacn_h,
    output logic [ADC_BITS-1:1] dacn_l,
    output logic [ADC_BITS-1:0] data,
    output logic                valid,
    output logic                busy,
    output logic                timeout
);

    localparam int unsigned MaxSs   = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES
                                                                       : SETTLE_CYCLES;
    localparam int unsigned MaxWait = (MaxSs > COMP_TIMEOUT) ? MaxSs : COMP_TIMEOUT;
    localparam int unsigned CntW    = $clog2(MaxWait);
    localparam int unsigned PtrW    = $clog2(ADC_BITS);

    sar_state_e           state;
    logic [PtrW-1:0]      bit_ptr;
    logic [ADC_BITS-1:1]  result;
    logic                 to_flag;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;
    logic [CntW-1:0]      cnt_val;
    logic                 decision;

    // A missing comp_done forces the decision to 0.
    assign decision = comp_done & comp;

    sar_wait_cnt #(
        .WIDTH (CntW)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_val),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            StIdle: begin
                if (start) begin
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(SAMPLE_CYCLES - 1);
                end
            end
            StSample: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StSettle: begin
                cnt_dec = ~cnt_zero;
            end
            StCompare: begin
                if (comp_en) begin
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(COMP_TIMEOUT - 1);
                end else if (comp_done || cnt_zero) begin
                    if (bit_ptr != '0) begin
                        cnt_load = 1'b1;
                        cnt_val  = CntW'(SETTLE_CYCLES - 1);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            bit_ptr <= '0;
            result  <= '0;
            to_flag <= 1'b0;
            sample  <= 1'b0;
            comp_en <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            data    <= '0;
            dacp_h  <= '1;
            dacp_l  <= '0;
            dacn_h  <= '1;
            dacn_l  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StSample;
                        sample  <= 1'b1;
                        busy    <= 1'b1;
                        to_flag <= 1'b0;
                    end
                end
                StSample: begin
                    if (cnt_zero) begin
                        state   <= StSettle;
                        sample  <= 1'b0;
                        bit_ptr <= PtrW'(ADC_BITS - 1);
                    end
                end
                StSettle: begin
                    if (cnt_zero) begin
                        state   <= StCompare;
                        comp_en <= 1'b1;
                    end
                end
                StCompare: begin
                    // comp_done in the strobe cycle itself is not a decision.
                    if (comp_en) begin
                        comp_en <= 1'b0;
                    end else if (comp_done || cnt_zero) begin
                        if (!comp_done) begin
                            to_flag <= 1'b1;
                        end
                        if (bit_ptr != '0) begin
                            result[bit_ptr] <= decision;
                            if (decision) begin
                                {dacp_h[bit_ptr], dacp_l[bit_ptr]} <= CAP_VREFN;
                            end else begin
                                {dacn_h[bit_ptr], dacn_l[bit_ptr]} <= CAP_VREFN;
                            end
                            bit_ptr <= bit_ptr - PtrW'(1);
                            state   <= StSettle;
                        end else begin
                            state   <= StDone;
                            valid   <= 1'b1;
                            busy    <= 1'b0;
                            data    <= {result, decision};
                            timeout <= to_flag | ~comp_done;
                            dacp_h  <= '1;
                            dacp_l  <= '0;
                            dacn_h  <= '1;
                            dacn_l  <= '0;
                        end
                    end
                end
                StDone: begin
                    state   <= StIdle;
                    valid   <= 1'b0;
                    timeout <= 1'b0;
                    to_flag <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_logic.sv
// Bench for sar_logic: a charge-domain comparator responder plus a timeline
// model that predicts every output on every cycle of each conversion.
module tb_sar_logic;
    import sar_pkg::*;

    localparam int N   = 8;
    localparam int S   = 2;
    localparam int SET = 1;
    localparam int TO  = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic         comp;
    logic         comp_done;
    logic         sample;
    logic         comp_en;
    logic         valid;
    logic         busy;
    logic         timeout;
    logic [N-1:1] dacp_h;
    logic [N-1:1] dacp_l;
    logic [N-1:1] dacn_h;
    logic [N-1:1] dacn_l;
    logic [N-1:0] data;

    sar_logic #(
        .ADC_BITS      (N),
        .SAMPLE_CYCLES (S),
        .SETTLE_CYCLES (SET),
        .COMP_TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .comp      (comp),
        .comp_done (comp_done),
        .sample    (sample),
        .comp_en   (comp_en),
        .dacp_h    (dacp_h),
        .dacp_l    (dacp_l),
        .dacn_h    (dacn_h),
        .dacn_l    (dacn_l),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    typedef struct {
        logic         sample;
        logic         comp_en;
        logic         valid;
        logic         busy;
        logic         timeout;
        logic [N-1:1] ph;
        logic [N-1:1] pl;
        logic [N-1:1] nh;
        logic [N-1:1] nl;
        logic [N-1:0] data;
    } vec_t;

    vec_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           lat[N];
    int           en_idx[N];
    int           vd = 0;
    logic [N-1:0] last_data = '0;
    bit           chk_en = 0;
    int           valid_cnt = 0;
    int           v_cyc = 0;
    logic [N-1:0] v_data = '0;
    logic         v_to = 0;
    logic [N-1:1] prv_ph, prv_pl, prv_nh, prv_nl;
    logic [N-1:1] fin_ph, fin_pl, fin_nh, fin_nl;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic s, input logic ce, input logic v, input logic b,
                                input logic t, input logic [N-1:1] ph, input logic [N-1:1] pl,
                                input logic [N-1:1] nh, input logic [N-1:1] nl,
                                input logic [N-1:0] d);
        vec_t e;
        e.sample = s; e.comp_en = ce; e.valid = v; e.busy = b; e.timeout = t;
        e.ph = ph; e.pl = pl; e.nh = nh; e.nl = nl; e.data = d;
        return e;
    endfunction

    // Residual differential charge seen by the comparator, in LSB units.
    function automatic int analog();
        int r;
        r = vd;
        for (int k = 1; k < N; k++) begin
            if (dacp_l[k]) r -= (1 << (k - 1));
            if (dacn_l[k]) r += (1 << (k - 1));
        end
        return r;
    endfunction

    // Expected outputs cycle by cycle: entry 0 is the cycle in which start is raised.
    task automatic build_trace();
        logic [N-1:1] ph, pl, nh, nl;
        logic [N-1:0] code;
        logic         tof, dec;
        int           r, w, j;
        ph = '1; pl = '0; nh = '1; nl = '0; code = '0; tof = 0; r = vd; j = 0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, ph, pl, nh, nl, last_data)); j++;
        for (int i = 0; i < S; i++) begin
            exp_q.push_back(mk(1, 0, 0, 1, 0, ph, pl, nh, nl, last_data)); j++;
        end
        for (int k = N - 1; k >= 0; k--) begin
            for (int i = 0; i < SET; i++) begin
                exp_q.push_back(mk(0, 0, 0, 1, 0, ph, pl, nh, nl, last_data)); j++;
            end
            en_idx[k] = j;
            exp_q.push_back(mk(0, 1, 0, 1, 0, ph, pl, nh, nl, last_data)); j++;
            if (lat[k] > TO) begin
                w = TO; dec = 0; tof = 1;
            end else begin
                w = lat[k]; dec = (r > 0);
            end
            for (int i = 0; i < w; i++) begin
                exp_q.push_back(mk(0, 0, 0, 1, 0, ph, pl, nh, nl, last_data)); j++;
            end
            code[k] = dec;
            if (k >= 1) begin
                if (dec) begin
                    r -= (1 << (k - 1)); ph[k] = 0; pl[k] = 1;
                end else begin
                    r += (1 << (k - 1)); nh[k] = 0; nl[k] = 1;
                end
            end
        end
        exp_q.push_back(mk(0, 0, 1, 0, tof, '1, '0, '1, '0, code));
        last_data = code;
    endtask

    // Comparator responder: answers each strobe after lat[k] cycles (never if > TO),
    // and drives junk on comp/comp_done wherever the controller must ignore them.
    initial begin
        int cnt, cur, kc;
        bit win;
        win = 0; cnt = 0; cur = 0; kc = N - 1; comp = 0; comp_done = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!busy) begin
                win = 0; kc = N - 1;
                comp_done = 1'($urandom); comp = 1'($urandom);
            end else if (comp_en) begin
                win = 1; cnt = 0; cur = lat[kc]; kc--;
                comp_done = 1'($urandom); comp = 1'($urandom);
            end else if (win) begin
                cnt++;
                if (cnt == cur) begin
                    comp_done = 1; comp = (analog() > 0); win = 0;
                end else begin
                    comp_done = 0; comp = 1'($urandom);
                    if (cnt >= TO) win = 0;
                end
            end else begin
                comp_done = 1'($urandom); comp = 1'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        vec_t e;
        bit   ok;
        if (chk_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(0, 0, 0, 0, 0, '1, '0, '1, '0, last_data);
            ok = (sample === e.sample) && (comp_en === e.comp_en) && (valid === e.valid) &&
                 (busy === e.busy) && (timeout === e.timeout) && (dacp_h === e.ph) &&
                 (dacp_l === e.pl) && (dacn_h === e.nh) && (dacn_l === e.nl) &&
                 (data === e.data);
            for (int k = 1; k < N; k++) begin
                if ({dacp_h[k], dacp_l[k]} == 2'b11 || {dacp_h[k], dacp_l[k]} == CAP_VCM ||
                    {dacn_h[k], dacn_l[k]} == 2'b11 || {dacn_h[k], dacn_l[k]} == CAP_VCM)
                    ok = 0;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL cycle %0d outputs: got s%b e%b v%b b%b t%b p%h/%h n%h/%h d%h want s%b e%b v%b b%b t%b p%h/%h n%h/%h d%h",
                         cyc, sample, comp_en, valid, busy, timeout, dacp_h, dacp_l, dacn_h,
                         dacn_l, data, e.sample, e.comp_en, e.valid, e.busy, e.timeout, e.ph,
                         e.pl, e.nh, e.nl, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++; v_data = data; v_to = timeout; v_cyc = cyc;
            fin_ph = prv_ph; fin_pl = prv_pl; fin_nh = prv_nh; fin_nl = prv_nl;
        end
        prv_ph = dacp_h; prv_pl = dacp_l; prv_nh = dacn_h; prv_nl = dacn_l;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_bool(input string name, input bit cond, input logic [31:0] got);
        total++;
        if (!cond) begin
            bad++;
            $display("FAIL %s: got %0h, outside accepted set", name, got);
        end
    endtask

    // mode 0: 1-cycle comparator; 1: random latency with rare timeouts; 2: random, no timeouts
    task automatic set_lat(input int mode);
        for (int k = 0; k < N; k++) begin
            if (mode == 0) lat[k] = 1;
            else if (mode == 2 || $urandom_range(0, 9) != 0) lat[k] = int'($urandom_range(1, TO));
            else lat[k] = TO + 3;
        end
    endtask

    task automatic run_conv(input int v, input bit noisy, output int c0);
        vd = v;
        build_trace();
        c0 = cyc;
        start = 1;
        @(posedge clk); #1;
        start = noisy ? 1'($urandom) : 1'b0;
        for (int i = 0; i < 500 && exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = noisy ? 1'($urandom) : 1'b0;
        end
        start = 0;
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL conversion_bound: got %0d pending cycles want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int c0, vc0, gap;
        reset = 1; start = 0;
        set_lat(0);
        @(posedge clk); #1;
        chk_en = 1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 0;
        check("reset_sample", 32'(sample), 0);
        check("reset_comp_en", 32'(comp_en), 0);
        check("reset_valid_busy_timeout", {29'd0, valid, busy, timeout}, 0);
        check("reset_dacp", {dacp_h, dacp_l}, 14'h3F80);
        check("reset_dacn", {dacn_h, dacn_l}, 14'h3F80);
        check("reset_data", 32'(data), 0);
        @(posedge clk); #1;

        set_lat(0);
        run_conv(1000, 0, c0);
        check("ones_latency", 32'(v_cyc - c0), 27);
        check("ones_data", 32'(v_data), 32'hFF);
        check("ones_timeout", 32'(v_to), 0);
        check("ones_final_dacp", {fin_ph, fin_pl}, {7'h00, 7'h7F});
        check("ones_final_dacn", {fin_nh, fin_nl}, {7'h7F, 7'h00});

        run_conv(-1000, 0, c0);
        check("zeros_data", 32'(v_data), 32'h00);
        check("zeros_final_dacp", {fin_ph, fin_pl}, {7'h7F, 7'h00});
        check("zeros_final_dacn", {fin_nh, fin_nl}, {7'h00, 7'h7F});

        set_lat(2);
        run_conv(64, 0, c0);
        check_bool("loop_quarter", v_data == 8'hBF || v_data == 8'hC0, 32'(v_data));
        set_lat(2);
        run_conv(0, 0, c0);
        check_bool("loop_zero", v_data == 8'h7F || v_data == 8'h80, 32'(v_data));

        set_lat(0);
        lat[5] = TO + 5;
        run_conv(1000, 0, c0);
        check("to_data", 32'(v_data), 32'hDF);
        check("to_flag", 32'(v_to), 1);
        check("to_latency", 32'(v_cyc - c0), 34);
        set_lat(0);
        run_conv(1000, 0, c0);
        check("after_to_flag", 32'(v_to), 0);

        // Reset during the bit-3 comparator strobe cycle.
        set_lat(0);
        vd = 64;
        build_trace();
        vc0 = valid_cnt;
        start = 1;
        for (int i = 0; i < en_idx[3]; i++) begin @(posedge clk); #1; start = 0; end
        reset = 1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        last_data = '0;
        @(posedge clk); #1;
        reset = 0;
        check("rst_busy_comp_en", {30'd0, busy, comp_en}, 0);
        check("rst_dacp", {dacp_h, dacp_l}, 14'h3F80);
        check("rst_dacn", {dacn_h, dacn_l}, 14'h3F80);
        check("rst_data", 32'(data), 0);
        repeat (30) begin @(posedge clk); #1; end
        check("rst_no_valid", 32'(valid_cnt - vc0), 0);
        set_lat(2);
        run_conv(-20, 0, c0);
        check("post_rst_data", 32'(v_data), 32'h6B);

        vc0 = valid_cnt;
        set_lat(1);
        run_conv(int'($urandom_range(0, 600)) - 300, 1, c0);
        repeat (5) begin @(posedge clk); #1; end
        check("noisy_start_one_valid", 32'(valid_cnt - vc0), 1);

        for (int n = 0; n < 40; n++) begin
            set_lat(1);
            gap = int'($urandom_range(0, 2));
            for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
            run_conv(int'($urandom_range(0, 600)) - 300, $urandom_range(0, 3) == 0, c0);
        end
        repeat (5) begin @(posedge clk); #1; end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
